// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_pkg: shared width constants and word type for the adder.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int ADDER_BLOCK = 4;

    typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/adder_csel_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_csel_block: BLOCK-bit dual-carry adder with carry-select mux.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adder_csel_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK:0] w_res0;
    logic [BLOCK:0] w_res1;

    // Both carry-in outcomes are precomputed so the late carry only drives the mux.
    assign w_res0 = {1'b0, a} + {1'b0, b};
    assign w_res1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

    assign {cout, s} = cin ? w_res1 : w_res0;

endmodule
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder: carry-select two's-complement adder with overflow flag.       |
// | Optional output register enabled by ADDER_OUTPUT_REG_EN.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int BLOCK = ADDER_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int NBLK = WIDTH / BLOCK;

    logic [WIDTH-1:0] w_sum;
    logic [NBLK:1]    w_carry;
    logic             w_ovf;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        if (i == 0) begin : g_first
            // The first block sees cin directly, so a plain ripple add suffices.
            assign {w_carry[1], w_sum[BLOCK-1:0]} = {1'b0, a[BLOCK-1:0]}
                                                  + {1'b0, b[BLOCK-1:0]}
                                                  + {{BLOCK{1'b0}}, cin};
        end else begin : g_sel
            adder_csel_block #(
                .BLOCK (BLOCK)
            ) u_blk (
                .a    (a[i*BLOCK +: BLOCK]),
                .b    (b[i*BLOCK +: BLOCK]),
                .cin  (w_carry[i]),
                .s    (w_sum[i*BLOCK +: BLOCK]),
                .cout (w_carry[i+1])
            );
        end
    end

    assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ADDER_OUTPUT_REG_EN
    logic [WIDTH-1:0] r_sum;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_sum <= w_sum;
            r_ovf <= w_ovf;
        end
    end

    assign sum      = r_sum;
    assign overflow = r_ovf;

    logic w_unused;
    assign w_unused = &{1'b0, w_carry[NBLK]};
`else
    assign sum      = w_sum;
    assign overflow = w_ovf;

    // Clock and reset stay on the port list so both builds share one interface.
    logic w_unused;
    assign w_unused = &{1'b0, w_carry[NBLK], clk, rst};
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adder: randomized self-checking bench for adder.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adder;
    import adder_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    word_t a;
    word_t b;
    logic  cin;
    word_t sum;
    logic  overflow;

    int    total = 0;
    int    bad   = 0;
    word_t prev_sum;
    logic  prev_ovf;

    always #5 clk = ~clk;

    adder dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true integer arithmetic; overflow means the signed result leaves 32-bit range.
    function automatic void model(input word_t x, input word_t y, input logic c,
                                  output word_t s, output logic v);
        longint unsigned u;
        longint          sr;
        longint          lo;
        longint          hi;
        u  = longint'(x) + longint'(y) + longint'(c);
        s  = u[31:0];
        sr = longint'(signed'(x)) + longint'(signed'(y)) + longint'(c);
        lo = -(longint'(1) <<< 31);
        hi = (longint'(1) <<< 31) - 1;
        v  = (sr > hi) || (sr < lo);
    endfunction

    task automatic apply(input word_t x, input word_t y, input logic c, input logic r,
                         input string tag);
        word_t es;
        logic  ev;
        @(negedge clk);
        a   = x;
        b   = y;
        cin = c;
        rst = r;
        model(x, y, c, es, ev);
`ifdef ADDER_OUTPUT_REG_EN
        if (r) begin
            es = '0;
            ev = 1'b0;
        end
        #1;
        chk({tag, "_hold"}, sum, prev_sum);
        chk({tag, "_hold_ovf"}, {31'b0, overflow}, {31'b0, prev_ovf});
`else
        #1;
        chk({tag, "_comb"}, sum, es);
`endif
        @(posedge clk);
        #1;
        chk(tag, sum, es);
        chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, ev});
        prev_sum = es;
        prev_ovf = ev;
    endtask

    function automatic word_t pick();
        word_t w;
        case ($urandom_range(0, 7))
            0:       w = 32'h0000_0000;
            1:       w = 32'hFFFF_FFFF;
            2:       w = 32'h7FFF_FFFF;
            3:       w = 32'h8000_0000;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", sum, 32'h0);
        chk("reset_ovf", {31'b0, overflow}, 32'h0);
        prev_sum = '0;
        prev_ovf = 1'b0;

        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "pos_ovf");
        apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "neg_ovf");
        apply(32'hFFFF_FFFC, 32'h0000_0005, 1'b0, 1'b0, "wrap");
        apply(32'h0000_000A, 32'h0000_000A, 1'b0, 1'b0, "small");
        apply(32'hFFFF_FFF6, 32'hFFFF_FFEC, 1'b0, 1'b0, "neg_neg");
        apply(32'h0000_00A5, 32'h0000_03E8, 1'b0, 1'b0, "mix1");
        apply(32'hFFFF_FE0C, 32'h0000_07D0, 1'b0, 1'b0, "mix2");
        apply(32'hFFFF_FC19, 32'h0000_03E7, 1'b0, 1'b0, "mix3");
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "cin_ripple");
        apply(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "cin_ovf");
        apply(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, "mid_rst");
        apply(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, "post_rst");

        for (int i = 0; i < 300; i++) begin
            apply(pick(), pick(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder.md
# adder

Signed/unsigned two's-complement adder for the datapath: adds two WIDTH-bit operands plus a carry-in and produces the WIDTH-bit sum and a signed-overflow flag. The core is a carry-select structure built from fixed-size blocks. An optional output register stage sits at the datapath boundary.

## Interface
Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, carry-select block width in bits.

Ports:
- clk  input  1  single clock; all state is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- cin  input  1  carry-in, added at bit 0.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- overflow  output  1  signed overflow of the addition.

## Operation
- Full result: {carry, sum} = a + b + cin, computed as an unsigned (WIDTH+1)-bit add; the carry is internal only.
- overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]), evaluated on the unregistered sum.
- Carry chain: WIDTH/BLOCK blocks. Block 0 uses cin directly. Every other block computes its sum and carry for both carry-in 0 and 1, then selects with the previous block's carry-out.
- Operands are never sign-extended. Sum bits are identical for signed and unsigned interpretation; only overflow is signed.
- No handshake. The inputs are sampled continuously.

## Timing
- With ADDER_OUTPUT_REG_EN defined:
  - sum and overflow are registered, giving 1-cycle latency from an input change to the output.
  - When rst=1 at a rising edge, sum = 0 and overflow = 0 at that edge; rst dominates the input data.
  - Reset asserted mid-stream discards the in-flight result. The first valid output is one edge after rst deasserts.
- Without the macro:
  - sum and overflow are purely combinational, with zero latency.
  - clk and rst are present but unused.
- Inputs must be stable for one full clock period before they are consumed.

## Configuration
- Macro ADDER_OUTPUT_REG_EN:
  - Defined: output register stage with synchronous reset, as described in Timing.
  - Undefined: combinational outputs, and the port list stays unchanged.

## Structure
- Package adder_pkg holds:
  - the constants ADDER_WIDTH (32) and ADDER_BLOCK (4);
  - the typedef word_t (logic [ADDER_WIDTH-1:0]).
- One sub-module, adder_csel_block. It is a BLOCK-bit dual-carry adder with its own mux and has these ports:
  - inputs a, b, cin;
  - outputs s, cout.
- The top module instantiates it with a generate loop. It also contains the overflow logic and the optional register.

## Test plan
Build with ADDER_OUTPUT_REG_EN and check each result one edge after the stimulus.
- 7FFFFFFF + 00000001, cin=0 -> sum 80000000, overflow 1.
- 80000000 + FFFFFFFF, cin=0 -> sum 7FFFFFFF, overflow 1.
- FFFFFFFC + 00000005 -> 00000001, overflow 0.
- 0000000A + 0000000A -> 00000014, overflow 0.
- FFFFFFF6 + FFFFFFEC -> FFFFFFE2, overflow 0.
- Mixed-sign cases, all overflow 0:
  - 000000A5 + 000003E8 -> 0000048D;
  - FFFFFE0C + 000007D0 -> 000005DC;
  - FFFFFC19 + 000003E7 -> 00000000.
- cin=1 carry ripple: FFFFFFFF + 00000000 + 1 -> 00000000, overflow 0.
- rst=1 while the inputs are non-zero -> sum 00000000 and overflow 0 at that edge. Normal results resume one edge after rst deasserts.
